conv5x5_mac: RTL and testbench
==============================

# conv5x5_mac

- Convolution stage directly downstream of the 5x5 line buffer.
- Consumes each valid KX*KY pixel window and multiplies it element-wise by a loaded signed kernel.
- Sums the products, adds a bias, then scales and saturates the result to one output pixel per window.
- Its output feeds the pooling/activation stage of the Braille CNN.

## Interface
- I_F_BW, 8: input pixel width, unsigned
- W_BW, 8: weight width, two's complement
- KX, 5 / KY, 5: kernel width / height
- ACC_BW, 24: accumulator width, signed; must be ≥ I_F_BW+W_BW+1+clog2(KX*KY)
- OUT_SHIFT, 7: arithmetic right shift applied before saturation
- O_F_BW, 8: output pixel width
- clk  in  1  clock; all logic on the rising edge
- reset_n  in  1  synchronous reset, active-high (asserted = 1; port name kept for codebase consistency)
- i_window_valid  in  1  window present this cycle
- i_window  in  KX*KY*I_F_BW  slot s=(wy*KX+wx) at bits [s*I_F_BW +: I_F_BW]
- i_w_valid  in  1  weight word present
- i_w_data  in  W_BW  weight/bias word
- o_w_loaded  out  1  an active kernel exists; reset 0
- o_drop  out  1  sticky; set when a window arrives with no active kernel; cleared by reset only; reset 0
- o_valid  out  1  result valid; reset 0
- o_pixel  out  O_F_BW  result; reset 0

## Operation
- **Weight load**
  - Serial, KX*KY+1 words per kernel. Word k<KX*KY is weight for slot k; word KX*KY is bias.
  - Load counter 0..KX*KY advances on each i_w_valid; it wraps to 0 after the bias word.
  - Words land in a shadow bank.
  - On the cycle the bias word is accepted, shadow copies to the active bank atomically and o_w_loaded sets (registered, visible next cycle).
  - Bias is sign-extended to ACC_BW, then shifted left by OUT_SHIFT.
  - A partial load never disturbs active weights. Loading during streaming is legal; the swap takes effect for windows entering S1 on the cycle after the swap.
- **Datapath**, 4 registered stages, advancing every cycle with no stall (the upstream has no ready):
  - S1: 25 products, zero-extend pixel to I_F_BW+1 signed times weight, registered at I_F_BW+W_BW+1 bits.
  - S2: KY row partial sums, each summing KX products, registered at ACC_BW.
  - S3: sum of the row partials plus bias.
  - S4: arithmetic shift right by OUT_SHIFT (floor), then saturate per Configuration.
- **Valid**: a valid bit accompanies each stage.
  - A window accepted only when o_w_loaded=1. Otherwise it is discarded and o_drop sets.
- **Reset mid-operation**: clears all stage valids, the load counter, o_w_loaded, o_drop and o_pixel. The in-flight pipeline and any partial load are lost; active weights must be reloaded.
- Simultaneous i_w_valid and i_window_valid are independent, with no priority.

## Timing
- Latency: window at edge N produces o_valid/o_pixel at edge N+4; one result per cycle at full throughput.
- o_pixel holds its last value while o_valid=0.
- Bias word accepted at edge N: o_w_loaded=1 after edge N. A window presented at edge N+1 uses the new kernel.
- Back-to-back kernel reloads: every 26th word swaps; no idle cycle required.

## Configuration
- CONV_RELU_EN defined: negative results clamp to 0, and output saturates to unsigned [0, 2^O_F_BW-1].
- CONV_RELU_EN undefined: output is two's complement, saturated to [-2^(O_F_BW-1), 2^(O_F_BW-1)-1].

## Structure
- Shared package `cnn_pkg`: I_F_BW, W_BW, KX, KY, ACC_BW, O_F_BW defaults, the `sat_relu` and `sat_signed` functions, and the kernel word-count constant KX*KY+1.
- One sub-module, `conv_weight_bank`: shadow/active registers, load counter, swap and o_w_loaded.

## Test plan
- **Identity kernel**: centre weight 64, all others 0, bias 0, OUT_SHIFT=6; window with centre pixel 200 -> o_pixel=200, four cycles later.
- **All-ones kernel**: weights 1, bias 0, OUT_SHIFT=0, every pixel 10 -> 250. Then every pixel 11 -> 275, saturates to 255.
- **Negative result**: weights -1, bias 0, OUT_SHIFT=0, pixels 1 -> 0 with CONV_RELU_EN; -25 without.
- **Bias**: weights 0, bias word 3, OUT_SHIFT=7 -> 3.
- **No kernel**: windows before load -> no o_valid, o_drop=1. Reset -> o_drop=0, o_w_loaded=0.
- **Mid-stream reload**:
  - Stream 30 windows while loading a new kernel.
  - Windows entering before the swap use the old kernel; from the cycle after the bias word they use the new one.
  - No gaps in o_valid.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN constants and output saturation helpers for the Braille CNN datapath.
package cnn_pkg;

    localparam int unsigned I_F_BW = 8;
    localparam int unsigned W_BW   = 8;
    localparam int unsigned KX     = 5;
    localparam int unsigned KY     = 5;
    localparam int unsigned ACC_BW = 24;
    localparam int unsigned O_F_BW = 8;

    // Weights for every slot followed by one bias word.
    localparam int unsigned KernelWords = KX * KY + 1;

    localparam logic signed [ACC_BW-1:0] SatSMax = ACC_BW'((2 ** (O_F_BW - 1)) - 1);
    localparam logic signed [ACC_BW-1:0] SatSMin = ACC_BW'(-(2 ** (O_F_BW - 1)));
    localparam logic signed [ACC_BW-1:0] SatUMax = ACC_BW'((2 ** O_F_BW) - 1);

    function automatic logic [O_F_BW-1:0] sat_signed(input logic signed [ACC_BW-1:0] v);
        logic signed [ACC_BW-1:0] c;
        if (v > SatSMax) begin
            c = SatSMax;
        end else if (v < SatSMin) begin
            c = SatSMin;
        end else begin
            c = v;
        end
        return c[O_F_BW-1:0];
    endfunction

    function automatic logic [O_F_BW-1:0] sat_relu(input logic signed [ACC_BW-1:0] v);
        logic signed [ACC_BW-1:0] c;
        if (v > SatUMax) begin
            c = SatUMax;
        end else if (v < 0) begin
            c = '0;
        end else begin
            c = v;
        end
        return c[O_F_BW-1:0];
    endfunction

endpackage

// File: rtl/conv_weight_bank.sv
// Kernel store: serial load into a shadow bank, atomic swap to the active bank on the bias word.
module conv_weight_bank
    import cnn_pkg::*;
#(
    parameter int unsigned OUT_SHIFT = 7
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_w_valid,
    input  logic [W_BW-1:0]          i_w_data,
    output logic [KX*KY*W_BW-1:0]    o_weights,
    output logic signed [ACC_BW-1:0] o_bias,
    output logic                     o_w_loaded
);

    localparam int unsigned NTaps = KX * KY;
    localparam int unsigned CntW  = $clog2(KernelWords);

    logic [CntW-1:0]          cnt_q;
    logic                     loaded_q;
    logic [W_BW-1:0]          shadow_q [NTaps];
    logic [NTaps*W_BW-1:0]    active_q;
    logic signed [ACC_BW-1:0] bias_q;
    logic signed [ACC_BW-1:0] bias_word;
    logic                     is_bias;
    logic                     swap;

    assign is_bias   = (cnt_q == CntW'(NTaps));
    assign swap      = i_w_valid && is_bias && !reset_n;
    // Bias is pre-scaled so it lines up with the sum before the output shift.
    assign bias_word = ACC_BW'($signed(i_w_data)) <<< OUT_SHIFT;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            cnt_q    <= '0;
            loaded_q <= 1'b0;
        end else if (i_w_valid) begin
            cnt_q <= is_bias ? '0 : cnt_q + 1'b1;
            if (is_bias) begin
                loaded_q <= 1'b1;
            end
        end
    end

    // Kernel storage has no reset: o_w_loaded gates every use of it.
    always_ff @(posedge clk) begin
        if (i_w_valid && !is_bias) begin
            shadow_q[cnt_q] <= i_w_data;
        end
        if (swap) begin
            for (int k = 0; k < NTaps; k++) begin
                active_q[k*W_BW +: W_BW] <= shadow_q[k];
            end
            bias_q <= bias_word;
        end
    end

    assign o_weights  = active_q;
    assign o_bias     = bias_q;
    assign o_w_loaded = loaded_q;

endmodule

// File: rtl/conv5x5_mac.sv
// 5x5 convolution MAC: products, row sums, bias add, shift+saturate, output register.
// CONV_RELU_EN selects unsigned ReLU saturation instead of signed saturation.
module conv5x5_mac
    import cnn_pkg::*;
#(
    parameter int unsigned OUT_SHIFT = 7
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_window_valid,
    input  logic [KX*KY*I_F_BW-1:0]    i_window,
    input  logic                       i_w_valid,
    input  logic [W_BW-1:0]            i_w_data,
    output logic                       o_w_loaded,
    output logic                       o_drop,
    output logic                       o_valid,
    output logic [O_F_BW-1:0]          o_pixel
);

    localparam int unsigned NTaps = KX * KY;
    localparam int unsigned ProdW = I_F_BW + W_BW + 1;

    logic [NTaps*W_BW-1:0]    weights;
    logic signed [ACC_BW-1:0] bias;
    logic                     w_loaded;
    logic                     accept;

    logic [4:0]               valid_q;
    logic                     drop_q;
    logic signed [ProdW-1:0]  prod_d [NTaps];
    logic signed [ProdW-1:0]  prod_q [NTaps];
    logic signed [ACC_BW-1:0] bias1_q;
    logic signed [ACC_BW-1:0] bias2_q;
    logic signed [ACC_BW-1:0] row_d [KY];
    logic signed [ACC_BW-1:0] row_q [KY];
    logic signed [ACC_BW-1:0] sum_d;
    logic signed [ACC_BW-1:0] sum_q;
    logic signed [ACC_BW-1:0] shifted;
    logic [O_F_BW-1:0]        sat_d;
    logic [O_F_BW-1:0]        sat_q;
    logic [O_F_BW-1:0]        pixel_q;

    conv_weight_bank #(
        .OUT_SHIFT(OUT_SHIFT)
    ) u_weight_bank (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_w_valid (i_w_valid),
        .i_w_data  (i_w_data),
        .o_weights (weights),
        .o_bias    (bias),
        .o_w_loaded(w_loaded)
    );

    assign accept = i_window_valid && w_loaded;

    always_comb begin
        for (int s = 0; s < NTaps; s++) begin
            prod_d[s] = ProdW'($signed({1'b0, i_window[s*I_F_BW +: I_F_BW]}))
                      * ProdW'($signed(weights[s*W_BW +: W_BW]));
        end
    end

    always_comb begin
        for (int r = 0; r < KY; r++) begin
            row_d[r] = '0;
            for (int x = 0; x < KX; x++) begin
                row_d[r] = row_d[r] + ACC_BW'(prod_q[r*KX+x]);
            end
        end
    end

    // Bias travels with its window so a mid-stream swap never mixes kernels.
    always_comb begin
        sum_d = bias2_q;
        for (int r = 0; r < KY; r++) begin
            sum_d = sum_d + row_q[r];
        end
    end

    always_comb begin
        shifted = sum_q >>> OUT_SHIFT;
`ifdef CONV_RELU_EN
        sat_d = sat_relu(shifted);
`else
        sat_d = sat_signed(shifted);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            valid_q <= '0;
            drop_q  <= 1'b0;
            pixel_q <= '0;
        end else begin
            valid_q <= {valid_q[3:0], accept};
            if (i_window_valid && !w_loaded) begin
                drop_q <= 1'b1;
            end
            if (valid_q[3]) begin
                pixel_q <= sat_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        prod_q  <= prod_d;
        bias1_q <= bias;
        row_q   <= row_d;
        bias2_q <= bias1_q;
        sum_q   <= sum_d;
        sat_q   <= sat_d;
    end

    assign o_w_loaded = w_loaded;
    assign o_drop     = drop_q;
    assign o_valid    = valid_q[4];
    assign o_pixel    = pixel_q;

endmodule

// File: tb/tb_conv5x5_mac.sv
// Scoreboard bench for conv5x5_mac: directed windows/kernels, monitor checks value and latency.
module tb_conv5x5_mac;

    localparam int unsigned OutShift = 7;
    localparam int unsigned Centre   = 12;

`ifdef CONV_RELU_EN
    localparam logic [7:0] ESatHi = 8'd255;
    localparam logic [7:0] E248   = 8'd248;
    localparam logic [7:0] ENeg   = 8'd0;
    localparam logic [7:0] EM25   = 8'd0;
    localparam logic [7:0] EM1    = 8'd0;
    localparam logic [7:0] EBNeg  = 8'd0;
`else
    localparam logic [7:0] ESatHi = 8'd127;
    localparam logic [7:0] E248   = 8'd127;
    localparam logic [7:0] ENeg   = 8'h80;
    localparam logic [7:0] EM25   = 8'hE7;
    localparam logic [7:0] EM1    = 8'hFF;
    localparam logic [7:0] EBNeg  = 8'hFE;
`endif

    typedef struct {
        logic [7:0] pix;
        int         due;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic         i_window_valid;
    logic [199:0] i_window;
    logic         i_w_valid;
    logic [7:0]   i_w_data;
    logic         o_w_loaded;
    logic         o_drop;
    logic         o_valid;
    logic [7:0]   o_pixel;

    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    exp_t         sb[$];
    logic [7:0]   kw [25];
    logic [7:0]   kb;

    conv5x5_mac #(
        .OUT_SHIFT(OutShift)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_window_valid(i_window_valid),
        .i_window      (i_window),
        .i_w_valid     (i_w_valid),
        .i_w_data      (i_w_data),
        .o_w_loaded    (o_w_loaded),
        .o_drop        (o_drop),
        .o_valid       (o_valid),
        .o_pixel       (o_pixel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_valid === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL result_unexpected: got o_pixel=%0d at cycle %0d, none expected",
                             o_pixel, cyc);
                end else begin
                    e = sb.pop_front();
                    if (o_pixel !== e.pix || cyc != e.due) begin
                        n_fail++;
                        $display("FAIL result: got %0d at cycle %0d, expected %0d at cycle %0d",
                                 o_pixel, cyc, e.pix, e.due);
                    end
                end
            end
        end
    endtask

    function automatic logic [199:0] win(input logic [7:0] other, input logic [7:0] ctr);
        logic [199:0] w;
        w = {25{other}};
        w[Centre*8 +: 8] = ctr;
        return w;
    endfunction

    task automatic set_kernel(input logic [7:0] w_all, input logic [7:0] w_ctr,
                              input logic [7:0] b);
        for (int k = 0; k < 25; k++) kw[k] = (k == Centre) ? w_ctr : w_all;
        kb = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_window_valid = 1'b0;
            i_w_valid      = 1'b0;
        end
    endtask

    task automatic load_kernel();
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            i_window_valid = 1'b0;
            i_w_valid      = 1'b1;
            i_w_data       = (k < 25) ? kw[k] : kb;
        end
        idle(1);
    endtask

    // Output for a window sampled at the next edge appears four edges after it.
    task automatic send(input logic [199:0] w, input logic expect_out, input logic [7:0] exp);
        @(negedge clk);
        i_window_valid = 1'b1;
        i_window       = w;
        i_w_valid      = 1'b0;
        if (expect_out) sb.push_back('{pix: exp, due: cyc + 5});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n        = 1'b1;
        i_window_valid = 1'b0;
        i_w_valid      = 1'b0;
        idle(2);
        reset_n = 1'b0;
    endtask

    initial begin
        int first;
        int last;
        int vcount;
        reset_n        = 1'b1;
        i_window_valid = 1'b0;
        i_window       = '0;
        i_w_valid      = 1'b0;
        i_w_data       = '0;
        fork
            monitor();
        join_none

        do_reset();
        check("reset_o_valid", int'(o_valid), 0);
        check("reset_o_pixel", int'(o_pixel), 0);
        check("reset_o_w_loaded", int'(o_w_loaded), 0);
        check("reset_o_drop", int'(o_drop), 0);

        // Windows with no kernel are dropped
        send(win(8'd10, 8'd10), 1'b0, 8'd0);
        send(win(8'd20, 8'd20), 1'b0, 8'd0);
        send(win(8'd30, 8'd30), 1'b0, 8'd0);
        idle(8);
        check("nokernel_o_drop", int'(o_drop), 1);
        check("nokernel_o_w_loaded", int'(o_w_loaded), 0);
        do_reset();
        check("rst_clears_o_drop", int'(o_drop), 0);
        check("rst_clears_o_w_loaded", int'(o_w_loaded), 0);

        // Identity-style kernel: centre 64, shift 7 halves the centre pixel
        set_kernel(8'd0, 8'd64, 8'd0);
        load_kernel();
        check("loaded_after_bias", int'(o_w_loaded), 1);
        send(win(8'd255, 8'd200), 1'b1, 8'd100);
        send(win(8'd0, 8'd255), 1'b1, 8'd127);
        idle(6);

        // Partial load leaves the active kernel alone
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            i_w_valid = 1'b1;
            i_w_data  = 8'h7F;
        end
        send(win(8'd255, 8'd200), 1'b1, 8'd100);
        idle(6);
        check("partial_keeps_loaded", int'(o_w_loaded), 1);
        // Reset mid-load: the next full load must start at slot 0
        do_reset();
        check("rst_mid_load_loaded", int'(o_w_loaded), 0);

        set_kernel(8'd127, 8'd127, 8'd0);
        load_kernel();
        send({25{8'd255}}, 1'b1, ESatHi);
        send({25{8'd10}}, 1'b1, E248);
        send({25{8'd5}}, 1'b1, 8'd124);
        idle(6);

        set_kernel(8'h80, 8'h80, 8'd0);
        load_kernel();
        send({25{8'd255}}, 1'b1, ENeg);
        send({25{8'd1}}, 1'b1, EM25);
        idle(6);

        // -25 >>> 7 floors to -1
        set_kernel(8'hFF, 8'hFF, 8'd0);
        load_kernel();
        send({25{8'd1}}, 1'b1, EM1);
        idle(6);

        set_kernel(8'd0, 8'd0, 8'd3);
        load_kernel();
        send({25{8'd255}}, 1'b1, 8'd3);
        idle(6);
        set_kernel(8'd0, 8'd0, 8'hFE);
        load_kernel();
        send({25{8'd255}}, 1'b1, EBNeg);
        idle(6);

        // Mid-stream reload: old centre 64 gives p>>1, new centre 127 bias 5 gives p+4
        set_kernel(8'd0, 8'd64, 8'd0);
        load_kernel();
        idle(6);
        set_kernel(8'd0, 8'd127, 8'd5);
        first  = -1;
        last   = -1;
        vcount = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_valid === 1'b1) begin
                if (first < 0) first = cyc;
                last = cyc;
                vcount++;
            end
            i_window_valid = (c < 30);
            i_window       = {25{8'(c + 1)}};
            i_w_valid      = (c < 26);
            i_w_data       = (c < 25) ? kw[c] : kb;
            if (c < 30) begin
                sb.push_back('{pix: (c <= 25) ? 8'((c + 1) >> 1) : 8'(c + 5), due: cyc + 5});
            end
        end
        check("stream_valid_count", vcount, 30);
        check("stream_no_gaps", last - first + 1, 30);
        idle(3);
        check("hold_o_valid_low", int'(o_valid), 0);
        check("hold_o_pixel", int'(o_pixel), 34);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
